cache_instructions: RTL and testbench
=====================================

CACHE_INSTRUCTIONS -- requirements
Module: cache_instructions

Interface
REQ-001 SHALL have parameter ADDRESS_BITWIDTH, default 32: width of the instruction byte address.
REQ-002 SHALL have parameter DATA_BITWIDTH, default 32: instruction width (4 B).
REQ-003 SHALL have parameter RAM_DEPTH_BITWIDTH, default 4: width of the burst-RAM word address, in 64-bit words.
REQ-004 SHALL have parameter RAM_BURST_DATA_BITWIDTH, default 64: width of one burst beat.
REQ-005 SHALL have parameter RAM_BURST_DATA_COUNT, default 4: beats per burst, giving a 32 B cache line.
REQ-006 SHALL have parameter LINE_IX_BITWIDTH, default 1: log2 of the number of lines (2 lines).
REQ-007 SHALL have ports: clk in 1, clock, all logic on rising edge; rst in 1, reset.
REQ-008 SHALL have ports: enable in 1, fetch request; address in ADDRESS_BITWIDTH, byte address, 4-aligned.
REQ-009 SHALL have ports: data out DATA_BITWIDTH, instruction; data_valid out 1, data holds the requested instruction; busy out 1, requests not accepted.
REQ-010 SHALL have ports: br_cmd out 1, 0=read, always 0; br_cmd_en out 1, command strobe; br_addr out RAM_DEPTH_BITWIDTH, 64-bit word address.
REQ-011 SHALL have ports: br_rd_data in RAM_BURST_DATA_BITWIDTH, beat data; br_rd_data_valid in 1, beat strobe; br_busy in 1, RAM not ready.
REQ-012 SHALL use one clock, clk; reset rst SHALL be asynchronous and active-high.

Function
REQ-013 SHALL be a direct-mapped, read-only cache. Per line it SHALL hold a valid bit, a tag and 256 data bits.
REQ-014 SHALL decode the address as: [1:0] ignored; [4:2] instruction-in-line index; [5+LINE_IX_BITWIDTH-1:5] line index; the remaining upper bits are the tag.
REQ-015 SHALL store instruction k of a line at line bits [32k+31:32k]. Beat j SHALL fill line bits [64j+63:64j], so the lower address sits in the lower half (little-endian).
REQ-016 SHALL implement the states INIT, IDLE, FETCH_CMD, FETCH_READ.
REQ-017 INIT: busy=1; SHALL clear one line's valid bit per cycle, then go to IDLE once all lines are cleared and br_busy=0.
REQ-018 IDLE: busy=0; SHALL sample enable at each rising edge.
REQ-019 IDLE hit (enable=1, line valid, tag equal): at that edge SHALL register data=the selected instruction and data_valid=1, and increment stat_cache_hits. Latency is 1 cycle; back-to-back hits SHALL be accepted every cycle.
REQ-020 IDLE miss: SHALL increment stat_cache_misses, latch the address, clear data_valid, set busy=1 and go to FETCH_CMD.
REQ-021 FETCH_CMD: when br_busy=0, SHALL pulse br_cmd_en=1 for exactly one cycle with br_cmd=0 and br_addr=(line base byte address)>>3, truncated to RAM_DEPTH_BITWIDTH, then go to FETCH_READ.
REQ-022 FETCH_READ: each cycle with br_rd_data_valid=1 SHALL store the next beat (counter 0..RAM_BURST_DATA_COUNT-1).
REQ-023 FETCH_READ: when the beat containing the requested instruction arrives, SHALL drive data with it and set data_valid=1, even though the burst is unfinished.
REQ-024 After the last beat, SHALL write tag and valid=1 into the line (evicting the old contents) and return to IDLE; busy SHALL fall then.
REQ-025 SHALL hold data and data_valid until the next accepted request, and SHALL ignore enable while busy=1.
REQ-026 Hit test SHALL use stored line state only; no forwarding from an in-progress fill.
REQ-027 Statistics counters stat_cache_hits and stat_cache_misses SHALL be 32-bit internal registers, wrapping on overflow.

Reset
REQ-028 While rst=1: data=0, data_valid=0, busy=1, br_cmd=0, br_cmd_en=0, br_addr=0, both counters=0, state=INIT.
REQ-029 Reset during a fetch SHALL abandon it and force INIT. Beats still arriving after reset SHALL be ignored until a new command is issued.

Verification (test image: 16 x 64-bit words, RAM read latency 3 cycles, burst of 4)
REQ-030 After reset, busy deasserts; enable @0 (miss) -> data_valid with data=0xB7C6A980, stat_cache_misses=1; busy deasserts later.
REQ-031 Single-cycle enables @4, @8, @16 back-to-back -> one cycle after each request: 0x3F5A2E14, 0xAB4C3E6F, 0xD5B8A9C4; stat_cache_hits=1,2,3.
REQ-032 Enable @32 (line 1 miss) -> data=0x2F5E3C7A, stat_cache_misses=2.
REQ-033 Enable @68 (line 0 eviction) -> data=0x0A1B2C3D, stat_cache_misses=3; a re-request @0 SHALL then miss.
REQ-034 Assert rst mid-FETCH_READ -> outputs at reset values, INIT re-run; a subsequent request @0 SHALL miss and return 0xB7C6A980.

Source files
------------

// File: rtl/cache_instructions.sv
// Direct-mapped, read-only instruction cache that refills whole lines from a burst RAM.
// The requested instruction is returned as soon as its beat arrives; the rest of the burst completes in the background.
module cache_instructions #(
  parameter int ADDRESS_BITWIDTH        = 32,
  parameter int DATA_BITWIDTH           = 32,
  parameter int RAM_DEPTH_BITWIDTH      = 4,
  parameter int RAM_BURST_DATA_BITWIDTH = 64,
  parameter int RAM_BURST_DATA_COUNT    = 4,
  parameter int LINE_IX_BITWIDTH        = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic [ADDRESS_BITWIDTH-1:0]        address,
  output logic [DATA_BITWIDTH-1:0]           data,
  output logic                               data_valid,
  output logic                               busy,
  output logic                               br_cmd,
  output logic                               br_cmd_en,
  output logic [RAM_DEPTH_BITWIDTH-1:0]      br_addr,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0] br_rd_data,
  input  logic                               br_rd_data_valid,
  input  logic                               br_busy
);

  localparam int NUM_LINES  = 1 << LINE_IX_BITWIDTH;
  localparam int LINE_W     = RAM_BURST_DATA_BITWIDTH * RAM_BURST_DATA_COUNT;
  localparam int OFFSET_W   = $clog2(LINE_W / 8);
  localparam int BYTE_W     = $clog2(DATA_BITWIDTH / 8);
  localparam int WORD_IX_W  = $clog2(LINE_W / DATA_BITWIDTH);
  localparam int TAG_W      = ADDRESS_BITWIDTH - OFFSET_W - LINE_IX_BITWIDTH;
  localparam int IPB        = RAM_BURST_DATA_BITWIDTH / DATA_BITWIDTH;
  localparam int BEAT_SHIFT = $clog2(IPB);
  localparam int BEAT_W     = $clog2(RAM_BURST_DATA_COUNT);
  localparam int WORD_SHIFT = $clog2(RAM_BURST_DATA_BITWIDTH / 8);

  typedef enum logic [1:0] {INIT, IDLE, FETCH_CMD, FETCH_READ} state_t;

  state_t                      state;
  logic [NUM_LINES-1:0]        valid;
  logic [TAG_W-1:0]            tag_mem   [NUM_LINES];
  logic [LINE_W-1:0]           line_data [NUM_LINES];
  logic [LINE_IX_BITWIDTH-1:0] init_ix;
  logic                        init_done;
  logic [BEAT_W-1:0]           beat_cnt;
  logic [TAG_W-1:0]            fetch_tag;
  logic [LINE_IX_BITWIDTH-1:0] fetch_ix;
  logic [WORD_IX_W-1:0]        fetch_word;
  logic [31:0]                 stat_cache_hits;
  logic [31:0]                 stat_cache_misses;

  logic [TAG_W-1:0]            req_tag;
  logic [LINE_IX_BITWIDTH-1:0] req_ix;
  logic [WORD_IX_W-1:0]        req_word;
  logic                        hit;
  logic [DATA_BITWIDTH-1:0]    hit_word;
  logic [DATA_BITWIDTH-1:0]    beat_word;
  logic [WORD_IX_W-1:0]        req_beat_full;
  logic [ADDRESS_BITWIDTH-1:0] line_word_addr;
  logic                        fill_we;
  logic                        last_beat;
  logic                        unused;

  assign req_tag  = address[ADDRESS_BITWIDTH-1 -: TAG_W];
  assign req_ix   = address[OFFSET_W +: LINE_IX_BITWIDTH];
  assign req_word = address[BYTE_W +: WORD_IX_W];
  assign hit      = valid[req_ix] && (tag_mem[req_ix] == req_tag);
  assign hit_word = line_data[req_ix][req_word*DATA_BITWIDTH +: DATA_BITWIDTH];

  // Beat that carries the instruction the stalled request is waiting for.
  assign req_beat_full  = fetch_word >> BEAT_SHIFT;
  assign beat_word      = br_rd_data[(int'(fetch_word) % IPB)*DATA_BITWIDTH +: DATA_BITWIDTH];
  assign line_word_addr = {fetch_tag, fetch_ix, {OFFSET_W{1'b0}}} >> WORD_SHIFT;
  assign fill_we        = (state == FETCH_READ) && br_rd_data_valid;
  assign last_beat      = (beat_cnt == BEAT_W'(RAM_BURST_DATA_COUNT - 1));
  assign unused         = ^{address[BYTE_W-1:0], line_word_addr};

  // Line storage has no reset; the valid bits alone decide whether its contents matter.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      line_data[fetch_ix][beat_cnt*RAM_BURST_DATA_BITWIDTH +: RAM_BURST_DATA_BITWIDTH] <= br_rd_data;
      if (last_beat) tag_mem[fetch_ix] <= fetch_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= INIT;
      data              <= '0;
      data_valid        <= 1'b0;
      busy              <= 1'b1;
      br_cmd            <= 1'b0;
      br_cmd_en         <= 1'b0;
      br_addr           <= '0;
      valid             <= '0;
      init_ix           <= '0;
      init_done         <= 1'b0;
      beat_cnt          <= '0;
      fetch_tag         <= '0;
      fetch_ix          <= '0;
      fetch_word        <= '0;
      stat_cache_hits   <= '0;
      stat_cache_misses <= '0;
    end else begin
      br_cmd    <= 1'b0;
      br_cmd_en <= 1'b0;
      case (state)
        INIT: begin
          busy <= 1'b1;
          if (!init_done) begin
            valid[init_ix] <= 1'b0;
            if (init_ix == LINE_IX_BITWIDTH'(NUM_LINES - 1)) init_done <= 1'b1;
            else init_ix <= init_ix + 1'b1;
          end else if (!br_busy) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (enable) begin
            if (hit) begin
              data            <= hit_word;
              data_valid      <= 1'b1;
              stat_cache_hits <= stat_cache_hits + 32'd1;
            end else begin
              // The victim line is invalidated up front so a half-filled line is never trusted.
              stat_cache_misses <= stat_cache_misses + 32'd1;
              fetch_tag         <= req_tag;
              fetch_ix          <= req_ix;
              fetch_word        <= req_word;
              valid[req_ix]     <= 1'b0;
              data_valid        <= 1'b0;
              busy              <= 1'b1;
              state             <= FETCH_CMD;
            end
          end
        end
        FETCH_CMD: begin
          if (!br_busy) begin
            br_cmd_en <= 1'b1;
            br_addr   <= line_word_addr[RAM_DEPTH_BITWIDTH-1:0];
            beat_cnt  <= '0;
            state     <= FETCH_READ;
          end
        end
        FETCH_READ: begin
          if (br_rd_data_valid) begin
            if (beat_cnt == req_beat_full[BEAT_W-1:0]) begin
              data       <= beat_word;
              data_valid <= 1'b1;
            end
            if (last_beat) begin
              valid[fetch_ix] <= 1'b1;
              busy            <= 1'b0;
              state           <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_instructions.sv
// Scoreboard bench for cache_instructions with a burst-RAM model (16 x 64-bit image, ~3-cycle latency).
module tb_cache_instructions;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] data;
  logic        data_valid;
  logic        busy;
  logic        br_cmd;
  logic        br_cmd_en;
  logic [3:0]  br_addr;
  logic [63:0] br_rd_data = '0;
  logic        br_rd_data_valid = 1'b0;
  logic        br_busy = 1'b0;

  always #5 clk = ~clk;

  cache_instructions dut (
    .clk(clk), .rst(rst), .enable(enable), .address(address),
    .data(data), .data_valid(data_valid), .busy(busy),
    .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr),
    .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid), .br_busy(br_busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          hit;
    int          hits;
    int          misses;
  } exp_t;

  exp_t        sb[$];
  logic [3:0]  brq[$];
  logic [63:0] mem [16];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Burst RAM model: independent of rst, so beats of an abandoned burst keep arriving.
  initial begin
    logic [3:0] base;
    for (int i = 0; i < 16; i++) mem[i] = {32'hC0DE0000 | i, 32'hF00D0000 | i};
    mem[0] = 64'h3F5A2E14_B7C6A980;
    mem[1] = 64'h11111111_AB4C3E6F;
    mem[2] = 64'h22222222_D5B8A9C4;
    mem[4] = 64'h55555555_2F5E3C7A;
    mem[8] = 64'h0A1B2C3D_66666666;
    forever begin
      @(posedge clk);
      if (br_cmd_en === 1'b1) begin
        base = br_addr;
        chk("br_cmd", {63'd0, br_cmd}, 64'd0);
        if (brq.size() == 0) chk("br_unexpected_cmd", {60'd0, br_addr}, 64'hFFFF);
        else chk("br_addr", {60'd0, br_addr}, {60'd0, brq.pop_front()});
        @(posedge clk);
        chk("br_cmd_en_pulse", {63'd0, br_cmd_en}, 64'd0);
        @(negedge clk);
        br_busy = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          br_rd_data       = mem[4'(base + j)];
          br_rd_data_valid = 1'b1;
        end
        @(negedge clk);
        br_rd_data_valid = 1'b0;
        br_rd_data       = '0;
        br_busy          = 1'b0;
      end
    end
  end

  // Monitor: a request accepted at a posedge is answered once data_valid is seen at a negedge.
  bit   mon_acc;
  bit   mon_wait = 0;
  bit   mon_first;
  int   mon_cyc;
  exp_t mon_e;
  initial begin
    forever begin
      @(posedge clk);
      mon_acc = !rst && enable && !busy;
      if (rst) mon_wait = 0;
      @(negedge clk);
      mon_first = mon_acc;
      if (mon_acc) begin
        mon_wait = 1;
        mon_cyc  = 0;
      end
      if (mon_wait) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_accept", {32'd0, address}, 64'hFFFF_FFFF_FFFF);
          mon_wait = 0;
        end else begin
          mon_e = sb[0];
          if (data_valid) begin
            void'(sb.pop_front());
            chk($sformatf("data@%0d", mon_e.addr), {32'd0, data}, {32'd0, mon_e.data});
            chk($sformatf("hits@%0d", mon_e.addr), {32'd0, dut.stat_cache_hits}, 64'(mon_e.hits));
            chk($sformatf("misses@%0d", mon_e.addr), {32'd0, dut.stat_cache_misses}, 64'(mon_e.misses));
            mon_wait = 0;
          end else if (mon_e.hit && mon_first) begin
            void'(sb.pop_front());
            chk($sformatf("hit_latency@%0d", mon_e.addr), {63'd0, data_valid}, 64'd1);
            mon_wait = 0;
          end else begin
            mon_cyc++;
            if (mon_cyc > 100) begin
              void'(sb.pop_front());
              chk($sformatf("timeout@%0d", mon_e.addr), {63'd0, data_valid}, 64'd1);
              mon_wait = 0;
            end
          end
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input bit h,
                       input int eh, input int em);
    exp_t e;
    e.addr = a; e.data = d; e.hit = h; e.hits = eh; e.misses = em;
    sb.push_back(e);
    if (!h) brq.push_back(4'(({a[31:5], 5'd0}) >> 3));
    address = a;
    enable  = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int i;
    for (i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !busy) break;
      @(negedge clk);
    end
    chk(name, {63'd0, busy}, 64'd0);
  endtask

  task automatic check_reset_values();
    chk("rst_data", {32'd0, data}, 64'd0);
    chk("rst_data_valid", {63'd0, data_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd1);
    chk("rst_br_cmd", {63'd0, br_cmd}, 64'd0);
    chk("rst_br_cmd_en", {63'd0, br_cmd_en}, 64'd0);
    chk("rst_br_addr", {60'd0, br_addr}, 64'd0);
    chk("rst_hits", {32'd0, dut.stat_cache_hits}, 64'd0);
    chk("rst_misses", {32'd0, dut.stat_cache_misses}, 64'd0);
  endtask

  initial begin
    int i;
    repeat (2) @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    wait_drain("init_done");

    issue(32'd0, 32'hB7C6A980, 0, 0, 1);
    enable = 1'b0;
    wait_drain("miss0_done");

    issue(32'd4,  32'h3F5A2E14, 1, 1, 1);
    issue(32'd8,  32'hAB4C3E6F, 1, 2, 1);
    issue(32'd16, 32'hD5B8A9C4, 1, 3, 1);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_data", {32'd0, data}, 64'hD5B8A9C4);
    chk("hold_valid", {63'd0, data_valid}, 64'd1);
    wait_drain("hits_done");

    issue(32'd32, 32'h2F5E3C7A, 0, 3, 2);
    // A would-be hit presented while busy must be ignored.
    address = 32'd4;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    wait_drain("miss32_done");

    issue(32'd68, 32'h0A1B2C3D, 0, 3, 3);
    enable = 1'b0;
    wait_drain("miss68_done");

    issue(32'd0, 32'hB7C6A980, 0, 3, 4);
    enable = 1'b0;
    for (i = 0; i < 100; i++) begin
      if (data_valid) break;
      @(negedge clk);
    end
    chk("early_data_valid", {63'd0, data_valid}, 64'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check_reset_values();
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    wait_drain("reinit_done");

    issue(32'd0, 32'hB7C6A980, 0, 0, 1);
    enable = 1'b0;
    wait_drain("post_reset_miss_done");
    issue(32'd4, 32'h3F5A2E14, 1, 1, 1);
    enable = 1'b0;
    wait_drain("post_reset_hit_done");

    repeat (12) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("brq_empty", 64'(brq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
